// File: rtl/sevenseg_scan_display_if.sv
// ============================================================================
// Module      : sevenseg_scan_display_if
// Description : Value/control inputs and active-low display outputs of the
//               seven-segment scan display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sevenseg_scan_display_if;
    logic [31:0] value_in;
    logic        freeze;
    logic        err_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    // Source side: drives the value and error status, observes the display.
    modport master (
        output value_in,
        output freeze,
        output err_in,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );

    // Display side.
    modport slave (
        input  value_in,
        input  freeze,
        input  err_in,
        output an,
        output seg,
        output dp,
        output frame_tick
    );
endinterface

`default_nettype wire

// File: rtl/sevenseg_scan_display.sv
// ============================================================================
// Module      : sevenseg_scan_display
// Description : Snapshots a 32-bit value once per scan frame and multiplexes
//               it as 8 hex digits onto a common-anode display (active-low).
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_scan_display #(
    parameter int SCAN_DIV = 100000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sevenseg_scan_display_if.slave bus
);

    localparam int                 c_PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);

    logic [c_PRE_W-1:0] r_prescaler;
    logic [2:0]         r_digit_idx;
    logic [31:0]        r_snapshot;
    logic               r_err_sticky;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_tick;

    logic               w_step;
    logic               w_wrap;
    logic [3:0]         w_nibble;
    logic [6:0]         w_hex;
    logic               w_blank;

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h40;
            4'h1:    p = 7'h79;
            4'h2:    p = 7'h24;
            4'h3:    p = 7'h30;
            4'h4:    p = 7'h19;
            4'h5:    p = 7'h12;
            4'h6:    p = 7'h02;
            4'h7:    p = 7'h78;
            4'h8:    p = 7'h00;
            4'h9:    p = 7'h10;
            4'hA:    p = 7'h08;
            4'hB:    p = 7'h03;
            4'hC:    p = 7'h46;
            4'hD:    p = 7'h21;
            4'hE:    p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    assign w_step   = (r_prescaler == c_PRE_LAST);
    assign w_wrap   = w_step && (r_digit_idx == 3'd7);
    assign w_nibble = r_snapshot[{r_digit_idx, 2'b00} +: 4];
    assign w_hex    = f_hex(w_nibble);

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] w_msd;

    // Index of the most-significant nonzero nibble; 0 for an all-zero snapshot.
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_snapshot[4*i +: 4] != 4'h0) begin
                w_msd = 3'(i);
            end
        end
    end

    // Digit 7 stays lit while the error flag is set so its decimal point is seen.
    assign w_blank = (r_digit_idx > w_msd) &&
                     !((r_digit_idx == 3'd7) && r_err_sticky);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler  <= '0;
            r_digit_idx  <= 3'd0;
            r_snapshot   <= 32'h0;
            r_err_sticky <= 1'b0;
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_err_sticky <= r_err_sticky | bus.err_in;
            r_frame_tick <= 1'b0;

            if (w_step) begin
                r_prescaler <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
                if (w_wrap && !bus.freeze) begin
                    r_snapshot   <= bus.value_in;
                    r_frame_tick <= 1'b1;
                end
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            // Drive registers see the pre-edge digit/snapshot: one cycle of latency.
            if (w_blank) begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(8'h01 << r_digit_idx);
                r_seg <= w_hex;
                r_dp  <= !((r_digit_idx == 3'd7) && r_err_sticky);
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_display.sv
// ============================================================================
// Module      : tb_sevenseg_scan_display
// Description : Self-checking bench for sevenseg_scan_display (SCAN_DIV=4);
//               honours LEADING_ZERO_BLANK_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_scan_display;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_scan_display_if bus ();

    sevenseg_scan_display #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] value;
        int          digit;
        logic [7:0]  an;
        logic [6:0]  seg;
    } vec_t;

    logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int passed = 0;
    int total  = 0;

    // Reference model: count of non-reset edges, shown snapshot and error flag.
    int          m_cnt;
    logic [31:0] m_snap;
    logic        m_err;
    logic [15:0] m_exp;
    logic        m_tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cnt);
        else passed++;
    endtask

    function automatic logic [15:0] expect_out(input int cnt, input logic [31:0] snap, input logic err);
        int         d;
        logic [3:0] nib;
        logic [7:0] an;
        logic       dp;
        d   = (cnt / SD) % 8;
        nib = 4'(snap >> (4 * d));
        an  = 8'hFF ^ (8'h01 << d);
        dp  = !(d == 7 && err);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 0; i < 8; i++) if (4'(snap >> (4 * i)) != 4'h0) msd = i;
            if (d > msd && !(d == 7 && err)) return {8'hFF, 7'h7F, 1'b1};
        end
`endif
        return {an, hex_lut[nib], dp};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_exp  = {8'hFF, 7'h7F, 1'b1};
            m_tick = 1'b0;
            m_cnt  = 0;
            m_snap = 32'h0;
            m_err  = 1'b0;
        end else begin
            m_exp  = expect_out(m_cnt, m_snap, m_err);
            m_err  = m_err | bus.err_in;
            m_cnt++;
            m_tick = 1'b0;
            if (m_cnt % FRAME == 0 && !bus.freeze) begin
                m_snap = bus.value_in;
                m_tick = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", 32'({bus.an, bus.seg, bus.dp, bus.frame_tick}), 32'({m_exp, m_tick}));
    endtask

    task automatic run_to(input int n);
        while (m_cnt < n) cycle();
    endtask

    task automatic chk_slot(input string name, input logic [7:0] an, input logic [6:0] seg);
        chk({name, "_an"}, 32'(bus.an), 32'(an));
        chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        logic [31:0] v;
        v = 32'h89ABCDEF;
        for (int i = 0; i < 8; i++) begin
            tbl[i].value = v;
            tbl[i].digit = i;
            tbl[i].an    = 8'hFF ^ (8'h01 << i);
        end
        tbl[0].seg = 7'h0E; tbl[1].seg = 7'h06; tbl[2].seg = 7'h21; tbl[3].seg = 7'h46;
        tbl[4].seg = 7'h03; tbl[5].seg = 7'h08; tbl[6].seg = 7'h10; tbl[7].seg = 7'h00;

        m_cnt = 0; m_snap = 0; m_err = 0; m_exp = 0; m_tick = 0;
        rst = 1'b1;
        bus.value_in = tbl[0].value;
        bus.freeze   = 1'b0;
        bus.err_in   = 1'b0;

        repeat (3) cycle();
        chk("reset_out", 32'({bus.an, bus.seg, bus.dp, bus.frame_tick}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));

        rst = 1'b0;
        cycle();
        chk_slot("first", 8'hFE, 7'h40);
        run_to(31);
        chk("tick_early", 32'(bus.frame_tick), 32'(0));
        cycle();
        chk("tick_wrap", 32'(bus.frame_tick), 32'(1));

        // Frame 2: the table; freeze raised and value changed mid-frame.
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.freeze = 1'b1;
            if (i == 3) bus.value_in = 32'h12345678;
            for (int j = 0; j < SD; j++) begin
                cycle();
                chk_slot($sformatf("f2_d%0d", tbl[i].digit), tbl[i].an, tbl[i].seg);
            end
        end
        chk("freeze_no_tick", 32'(bus.frame_tick), 32'(0));

        // Frame 3: frozen content; freeze dropped mid-frame so the wrap loads.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.freeze = 1'b0;
            for (int j = 0; j < SD; j++) begin
                cycle();
                chk_slot($sformatf("f3_d%0d", tbl[i].digit), tbl[i].an, tbl[i].seg);
            end
        end
        chk("unfreeze_tick", 32'(bus.frame_tick), 32'(1));
        cycle();
        chk_slot("new_d0", 8'hFE, 7'h00);

        // Single-cycle error pulse, then dp only on digit 7, every frame.
        bus.err_in = 1'b1;
        cycle();
        bus.err_in = 1'b0;
        run_to(122);
        chk("dp_d6", 32'(bus.dp), 32'(1));
        run_to(126);
        chk("dp_d7_an", 32'(bus.an), 32'(8'h7F));
        chk("dp_d7", 32'(bus.dp), 32'(0));
        run_to(158);
        chk("dp_repeat", 32'(bus.dp), 32'(0));

        // Reset while digit 3 is shown.
        run_to(174);
        chk("pre_rst_an", 32'(bus.an), 32'(8'hF7));
        rst = 1'b1;
        cycle();
        chk("midrst_out", 32'({bus.an, bus.seg, bus.dp, bus.frame_tick}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
        rst = 1'b0;
        bus.value_in = 32'h0000001A;
        cycle();
        chk_slot("restart", 8'hFE, 7'h40);
        run_to(30);
        chk("dp_cleared", 32'(bus.dp), 32'(1));

        // Leading-zero handling for 0x1A, then 0.
        run_to(34);
        chk_slot("lz_d0", 8'hFE, 7'h08);
        run_to(38);
        chk_slot("lz_d1", 8'hFD, 7'h79);
        run_to(42);
`ifdef LEADING_ZERO_BLANK_EN
        chk_slot("lz_d2", 8'hFF, 7'h7F);
`else
        chk_slot("lz_d2", 8'hFB, 7'h40);
`endif
        run_to(62);
`ifdef LEADING_ZERO_BLANK_EN
        chk_slot("lz_d7", 8'hFF, 7'h7F);
`else
        chk_slot("lz_d7", 8'h7F, 7'h40);
`endif
        bus.value_in = 32'h0;
        run_to(66);
        chk_slot("zero_d0", 8'hFE, 7'h40);
        run_to(70);
`ifdef LEADING_ZERO_BLANK_EN
        chk_slot("zero_d1", 8'hFF, 7'h7F);
`else
        chk_slot("zero_d1", 8'hFD, 7'h40);
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            bus.value_in = $urandom;
            if ($urandom_range(0, 15) == 0) bus.freeze = ~bus.freeze;
            bus.err_in = ($urandom_range(0, 199) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sevenseg_scan_display.md
Name: sevenseg_scan_display

Overview:
- Downstream display stage for the board-level top that exports the core's register r1.
- Snapshots a 32-bit value once per scan frame and time-multiplexes it as 8 hex digits onto a common-anode 8-digit seven-segment display.
- Latches a sticky bus-error indication on the decimal point of the most-significant digit.
- All display outputs are active-low.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit is held; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value_in  in  32  value to display (core r1)
- freeze  in  1  when 1, snapshot is not reloaded at frame wrap
- err_in  in  1  bus error from core; sampled every cycle
- an  out  8  digit enables, active-low, one-hot-low; an[0] = least-significant nibble
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when the snapshot loads

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high, and wins over all other inputs in the same cycle.
- Reset values: prescaler=0, digit_idx=0, snapshot=0, err_sticky=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler: counts 0..SCAN_DIV-1. At terminal count it returns to 0 and digit_idx advances mod 8 (7→0 wraps). With SCAN_DIV=1, digit_idx advances every cycle.
- Snapshot load: occurs on the edge where digit_idx wraps 7→0 and freeze=0. snapshot<=value_in and frame_tick=1 for exactly that cycle.
  - If freeze=1 at that edge: no load and no frame_tick.
  - freeze has no effect mid-frame; it matters only at the wrap edge.
- err_sticky: set on any cycle with err_in=1. Cleared only by rst.
- Outputs: an, seg and dp are registered with 1-cycle latency relative to digit_idx and snapshot.
  - an = ~(1<<digit_idx).
  - seg = hex pattern of snapshot[4*digit_idx+:4].
  - dp = 0 only when digit_idx==7 and err_sticky==1; otherwise 1.
- First cycle after reset release shows an=8'hFE, seg=7'h40.
- Hex patterns (active-low gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Frame coherence: all 8 digits of one frame come from the same snapshot. value_in changes mid-frame are never visible until the next load.
- Reset mid-frame: the next cycle shows reset values, and the scan restarts at digit 0 with a zero snapshot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits above the most-significant nonzero nibble of the snapshot are blanked (an bit held 1, seg=7'h7F, dp=1 for that slot). Scan timing is unchanged. Digit 0 is always shown, so snapshot=0 displays a single "0".
  - Exception: digit 7 is never blanked while err_sticky=1, so the error dp stays visible; its seg still shows its nibble.
- Undefined: all 8 digits are always driven, including leading zeros.

Test Plan:
- Reset: assert rst 3 cycles -> an=FF, seg=7F, dp=1, frame_tick=0. One cycle after release -> an=FE, seg=40, and the an sequence FE,FD,FB,...,7F repeats, each held SCAN_DIV cycles.
- SCAN_DIV=4, value_in=32'h89ABCDEF from reset release:
  - Cycle 32 -> frame_tick pulse.
  - Next frame shows digits 0..7 = F,E,d,C,b,A,9,8: seg 0E,06,21,46,03,08,10,00 with an FE..7F, each held 4 cycles.
- freeze=1 before wrap, then value_in=32'h12345678 -> display stays 89ABCDEF with no frame_tick. Deassert freeze -> next wrap loads, and digit 0 then shows seg=00 (8).
- 1-cycle err_in pulse -> dp=0 only while an=7F, repeating every frame until rst. After rst -> dp=1 always.
- rst asserted while an=F7 (digit 3) -> next cycle reset values; after release the scan restarts at an=FE with snapshot 0.
- LEADING_ZERO_BLANK_EN defined, value_in=32'h0000001A:
  - Digits 0,1 show 08,79; slots 2..7 give an=FF.
  - value_in=0 -> only digit 0 shows seg 40.
  - Macro undefined -> all 8 digits driven, upper six showing 40.
